// File: rtl/rom_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_stream_reader_if
//  Description : Bundle of the command, RAM-side and stream-side signals of
//                rom_stream_reader.
//                  start/baseAddr/count : transfer command (to reader)
//                  busy/done            : transfer status (from reader)
//                  memAddress/memData   : synchronous-read RAM port
//                  dataOut/dataValid/dataReady : valid/ready output stream
//                slave  modport = reader view, master modport = environment
//                view (command source, RAM and stream consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_stream_reader_if #(
  parameter int blockLength     = 32,
  parameter int addressBitWidth = 10
);
  logic                       start;
  logic [addressBitWidth-1:0] baseAddr;
  logic [addressBitWidth:0]   count;
  logic                       busy;
  logic                       done;
  logic [addressBitWidth-1:0] memAddress;
  logic [blockLength-1:0]     memData;
  logic [blockLength-1:0]     dataOut;
  logic                       dataValid;
  logic                       dataReady;

  modport slave (
    input  start, baseAddr, count, memData, dataReady,
    output busy, done, memAddress, dataOut, dataValid
  );

  modport master (
    output start, baseAddr, count, memData, dataReady,
    input  busy, done, memAddress, dataOut, dataValid
  );
endinterface
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_stream_reader
//  Description : Walks a contiguous RAM address window on a start command,
//                captures the 1-cycle-latency read data and presents it as a
//                valid/ready stream through a 2-entry output FIFO.
//  Ports       : clock  - rising-edge clock
//                reset  - synchronous active-high reset
//                bus    - rom_stream_reader_if.slave (command, status, RAM
//                         address/data, output stream)
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_stream_reader #(
  parameter int blockLength     = 32,
  parameter int addressBitWidth = 10
) (
  input  wire logic            clock,
  input  wire logic            reset,
  rom_stream_reader_if.slave   bus
);

  localparam int AW = addressBitWidth;
  localparam int BL = blockLength;

  localparam logic [AW-1:0] c_addr_one = 1;
  localparam logic [AW:0]   c_rem_one  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_addr;
  logic [AW:0]     r_remaining;
  logic            r_inflight;
  logic [BL-1:0]   r_buf [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_occ;
  logic            r_done;
  logic            w_done_next;

  logic            w_pop;
  logic            w_push;
  logic            w_latch;
  logic            w_issue;
  logic            w_drain_done;
  logic [2:0]      w_committed;

  assign w_pop   = (r_occ != 2'd0) && bus.dataReady;
  assign w_push  = r_inflight;
  assign w_latch = (r_state == S_IDLE) && bus.start;

  // Slots already claimed after this edge: buffered beats plus the read in
  // flight, minus the beat leaving now. A new read is issued only if it will
  // still find a free slot when its data arrives, so the FIFO cannot overflow.
  assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == S_RUN) && (r_remaining != '0) &&
                       (w_committed < 3'd2);

  // Finished once nothing is in flight and the last buffered beat leaves
  // this cycle (or the buffer is already empty), so done follows the final
  // acceptance by exactly one cycle.
  assign w_drain_done = (r_state == S_DRAIN) && !r_inflight &&
                        ((r_occ - {1'b0, w_pop}) == 2'd0);

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.count == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_issue && (r_remaining == c_rem_one)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;

      if (w_latch) begin
        r_addr      <= bus.baseAddr;
        r_remaining <= bus.count;
      end else if (w_issue) begin
        // Natural modulo-2^AW wrap of the address counter is intended.
        r_addr      <= r_addr + c_addr_one;
        r_remaining <= r_remaining - c_rem_one;
      end

      // The RAM sampled r_addr at this edge; its data is valid next cycle.
      r_inflight <= w_issue;

      if (w_push) begin
        r_buf[r_wr_ptr] <= bus.memData;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.memAddress = r_addr;
  assign bus.dataOut    = r_buf[r_rd_ptr];
  assign bus.dataValid  = (r_occ != 2'd0);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_stream_reader
//  Description : Self-checking bench for rom_stream_reader. A table of
//                transfers (window, length, ready pattern, expected first and
//                last beat) is replayed against a synchronous-read RAM model,
//                followed by hand-written count=0 and mid-transfer reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_stream_reader;

  localparam int BL = 32;
  localparam int AW = 10;
  localparam int MAX_CYCLES = 3000;

  logic clock;
  logic reset;

  rom_stream_reader_if #(.blockLength(BL), .addressBitWidth(AW)) bus ();

  rom_stream_reader #(.blockLength(BL), .addressBitWidth(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read RAM, ram[i] = i + 0x100.
  logic [BL-1:0] ram [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'(i) + 32'h100;
  end
  always @(posedge clock) bus.memData <= ram[bus.memAddress];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    int            mode;       // 0: ready always high, 1: toggle pattern
    int            restart_k;  // cycle of an extra start pulse, 0 = none
    bit            chk_addr;   // check first four issued addresses
    logic [BL-1:0] exp_first;
    logic [BL-1:0] exp_last;
  } vec_t;

  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic run_vec(input vec_t v, input string tag);
    int k, beats, first_k, last_k, done_k;
    int busy_bad, stall_bad, occ_bad;
    bit valid_at_done, busy_at_done, prev_stall, rdy;
    logic [BL-1:0] prev_data, first_data, last_data, expd;
    logic [AW-1:0] a;
    logic [AW-1:0] alog [4];

    @(negedge clock);
    bus.start     = 1'b1;
    bus.baseAddr  = v.base;
    bus.count     = v.cnt;
    bus.dataReady = 1'b0;
    k = 0; beats = 0; first_k = -1; last_k = -1; done_k = -1;
    busy_bad = 0; stall_bad = 0; occ_bad = 0;
    valid_at_done = 0; busy_at_done = 1; prev_stall = 0;
    prev_data = '0; first_data = '0; last_data = '0;
    for (int i = 0; i < 4; i++) alog[i] = '0;

    // Cycle k is observed on the k-th falling edge after the start edge.
    while (done_k < 0 && k < MAX_CYCLES) begin
      @(negedge clock);
      k++;
      bus.start = (v.restart_k != 0) && (k == v.restart_k);
      if (bus.start) begin
        bus.baseAddr = 10'h200;
        bus.count    = 11'd3;
      end
      if (k <= 4) alog[k-1] = bus.memAddress;
      if (dut.r_occ > 2'd2) occ_bad++;
      if (prev_stall && (!bus.dataValid || bus.dataOut !== prev_data)) stall_bad++;
      if (bus.done) begin
        done_k        = k;
        busy_at_done  = bus.busy;
        valid_at_done = bus.dataValid;
      end else if (!bus.busy) begin
        busy_bad++;
      end
      rdy = (v.mode == 0) ? 1'b1 : pat[(k - 1) % 7];
      bus.dataReady = rdy;
      if (bus.dataValid && first_k < 0) first_k = k;
      if (bus.dataValid && rdy && !bus.done) begin
        a    = v.base + AW'(beats);
        expd = BL'(a) + 32'h100;
        chk({tag, "_beat"}, bus.dataOut, expd);
        if (beats == 0) first_data = bus.dataOut;
        last_data = bus.dataOut;
        beats++;
        last_k = k;
      end
      prev_stall = bus.dataValid && !rdy;
      prev_data  = bus.dataOut;
    end
    bus.start = 1'b0;

    chk({tag, "_done_seen"}, (done_k > 0), 1);
    chk({tag, "_beats"}, beats, v.cnt);
    chk({tag, "_busy_low_at_done"}, busy_at_done, 0);
    chk({tag, "_valid_low_at_done"}, valid_at_done, 0);
    chk({tag, "_busy_gaps"}, busy_bad, 0);
    chk({tag, "_stall_stability"}, stall_bad, 0);
    chk({tag, "_occupancy"}, occ_bad, 0);
    if (v.cnt != 0) begin
      chk({tag, "_first"}, first_data, v.exp_first);
      chk({tag, "_last"}, last_data, v.exp_last);
      // valid rises at the second edge after the start edge
      chk({tag, "_latency"}, first_k - 1, 2);
      chk({tag, "_done_after_last"}, done_k, last_k + 1);
      if (v.mode == 0) chk({tag, "_back_to_back"}, last_k - first_k, v.cnt - 1);
    end else begin
      chk({tag, "_done_cycle"}, done_k, 2);
    end
    if (v.chk_addr) begin
      for (int i = 0; i < 4; i++) begin
        a = v.base + AW'(i);
        chk({tag, "_mem_addr"}, alog[i], a);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk({tag, "_single_done"}, bus.done, 0);
      chk({tag, "_idle_valid"}, bus.dataValid, 0);
    end
  endtask

  vec_t vecs [5];
  vec_t v_after_reset;

  initial begin
    vecs[0] = '{base: 10'h010, cnt: 11'd4,    mode: 0, restart_k: 0, chk_addr: 1'b0,
                exp_first: 32'h110, exp_last: 32'h113};
    vecs[1] = '{base: 10'h010, cnt: 11'd8,    mode: 1, restart_k: 5, chk_addr: 1'b0,
                exp_first: 32'h110, exp_last: 32'h117};
    vecs[2] = '{base: 10'h3FE, cnt: 11'd4,    mode: 0, restart_k: 0, chk_addr: 1'b1,
                exp_first: 32'h4FE, exp_last: 32'h101};
    vecs[3] = '{base: 10'h000, cnt: 11'd1024, mode: 0, restart_k: 0, chk_addr: 1'b0,
                exp_first: 32'h100, exp_last: 32'h4FF};
    vecs[4] = '{base: 10'h3FF, cnt: 11'd1,    mode: 1, restart_k: 0, chk_addr: 1'b0,
                exp_first: 32'h4FF, exp_last: 32'h4FF};
    v_after_reset = '{base: 10'h020, cnt: 11'd2, mode: 0, restart_k: 0, chk_addr: 1'b0,
                      exp_first: 32'h120, exp_last: 32'h121};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.baseAddr  = '0;
    bus.count     = '0;
    bus.dataReady = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_valid", bus.dataValid, 0);
    chk("reset_addr", bus.memAddress, 0);
    chk("reset_dataout", bus.dataOut, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", bus.busy, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // count=0, with a second start held through the busy cycle.
    @(negedge clock);
    bus.start = 1'b1; bus.baseAddr = 10'h050; bus.count = 11'd0; bus.dataReady = 1'b1;
    @(negedge clock);
    chk("zero_busy", bus.busy, 1);
    chk("zero_done_early", bus.done, 0);
    bus.baseAddr = 10'h300; bus.count = 11'd5;   // ignored: not IDLE
    @(negedge clock);
    bus.start = 1'b0;
    chk("zero_done", bus.done, 1);
    chk("zero_busy_end", bus.busy, 0);
    chk("zero_valid", bus.dataValid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("zero_no_restart_busy", bus.busy, 0);
      chk("zero_no_beats", bus.dataValid, 0);
      chk("zero_single_done", bus.done, 0);
    end

    // Reset three cycles into a stalled count=16 transfer.
    @(negedge clock);
    bus.start = 1'b1; bus.baseAddr = 10'h000; bus.count = 11'd16; bus.dataReady = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_valid", bus.dataValid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_addr", bus.memAddress, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_no_done", bus.done, 0);
    chk("abort_idle", bus.busy, 0);
    run_vec(v_after_reset, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
